// File: rtl/rc5_key_expand.sv
// RC5 key-expansion engine: loads key bytes into L, initialises S from Pw/Qw, then runs
// the 3*max(T,C) mixing pass over three external single-port synchronous RAMs.
module rc5_key_expand #(
  parameter int unsigned W = 32,
  parameter int unsigned R = 12,
  parameter int unsigned B = 16,
  parameter logic [W-1:0] P = 32'hB7E15163,
  parameter logic [W-1:0] Q = 32'h9E3779B9,
  localparam int unsigned U   = W / 8,
  localparam int unsigned CR  = (B + U - 1) / U,
  localparam int unsigned C   = (CR > 0) ? CR : 1,
  localparam int unsigned T   = 2 * (R + 1),
  localparam int unsigned KAW = (B > 1) ? $clog2(B) : 1,
  localparam int unsigned LAW = (C > 1) ? $clog2(C) : 1,
  localparam int unsigned TAW = (T > 1) ? $clog2(T) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [KAW-1:0] key_address,
  input  logic [7:0]     key_sub_i,
  output logic [LAW-1:0] L_address,
  input  logic [W-1:0]   L_sub_i,
  output logic [W-1:0]   L_sub_i_prima,
  output logic           L_we,
  output logic [TAW-1:0] S_address,
  input  logic [W-1:0]   S_sub_i,
  output logic [W-1:0]   S_sub_i_prima,
  output logic           S_we
);

  localparam int unsigned M   = (T > C) ? T : C;
  localparam int unsigned NIT = 3 * M;
  localparam int unsigned ITW = $clog2(NIT);
  localparam int unsigned LW  = $clog2(W);
  localparam int unsigned UW  = $clog2(U);

  typedef enum logic [2:0] {
    IDLE, LOAD, LDRAIN, SINIT, MIX_RD, MIX_WR, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [KAW-1:0] k_q, k_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [TAW-1:0] n_q, n_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [TAW-1:0] i_q, i_d;
  logic [LAW-1:0] j_q, j_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [ITW-1:0] it_q, it_d;
  logic [W-1:0]   l_wd_q, l_wd_d;
  logic [W-1:0]   s_wd_q, s_wd_d;

  logic [KAW-1:0] key_addr_c;
  logic [LAW-1:0] l_addr_c;
  logic [TAW-1:0] s_addr_c;
  logic           l_we_c, s_we_c;
  logic [W-1:0]   l_wdata_c, s_wdata_c;
  logic [W-1:0]   acc_n_c;
  logic           load_dv_c;
  logic [KAW-1:0] load_dk_c;
  logic [W-1:0]   a_new_c, ab_c, b_new_c;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    rotl = (x << n) | (x >> (W - 32'(n)));
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      it_q    <= '0;
      l_wd_q  <= '0;
      s_wd_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      it_q    <= it_d;
      l_wd_q  <= l_wd_d;
      s_wd_q  <= s_wd_d;
    end
  end

  // Next-state, RAM control and mixing datapath
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    n_d        = n_q;
    sum_d      = sum_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    it_d       = it_q;
    key_addr_c = '0;
    l_addr_c   = '0;
    s_addr_c   = '0;
    l_we_c     = 1'b0;
    s_we_c     = 1'b0;
    l_wdata_c  = l_wd_q;
    s_wdata_c  = s_wd_q;

    acc_n_c   = W'({acc_q, key_sub_i});
    load_dv_c = ((state_q == LOAD) && (k_q != KAW'(B - 1))) || (state_q == LDRAIN);
    load_dk_c = (state_q == LDRAIN) ? '0 : KAW'(k_q + 1'b1);
    a_new_c   = rotl(S_sub_i + a_q + b_q, LW'(3));
    ab_c      = a_new_c + b_q;
    b_new_c   = rotl(L_sub_i + ab_c, ab_c[LW-1:0]);

    // Key byte read one cycle earlier lands now; a word is complete at each U-aligned byte
    if (load_dv_c) begin
      acc_d = acc_n_c;
      if ((load_dk_c & KAW'(U - 1)) == '0) begin
        l_we_c    = 1'b1;
        l_addr_c  = LAW'(load_dk_c >> UW);
        l_wdata_c = acc_n_c;
        acc_d     = '0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = KAW'(B - 1);
          acc_d   = '0;
          a_d     = '0;
          b_d     = '0;
          i_d     = '0;
          j_d     = '0;
          it_d    = '0;
        end
      end
      LOAD: begin
        key_addr_c = k_q;
        if (k_q == '0) state_d = LDRAIN;
        else           k_d     = k_q - 1'b1;
      end
      LDRAIN: begin
        state_d = SINIT;
        n_d     = '0;
        sum_d   = P;
      end
      SINIT: begin
        s_we_c    = 1'b1;
        s_addr_c  = n_q;
        s_wdata_c = sum_q;
        sum_d     = sum_q + Q;
        n_d       = n_q + 1'b1;
        if (n_q == TAW'(T - 1)) state_d = MIX_RD;
      end
      MIX_RD: begin
        s_addr_c = i_q;
        l_addr_c = j_q;
        state_d  = MIX_WR;
      end
      MIX_WR: begin
        s_addr_c  = i_q;
        l_addr_c  = j_q;
        s_we_c    = 1'b1;
        l_we_c    = 1'b1;
        s_wdata_c = a_new_c;
        l_wdata_c = b_new_c;
        a_d       = a_new_c;
        b_d       = b_new_c;
        i_d       = (i_q == TAW'(T - 1)) ? '0 : i_q + 1'b1;
        j_d       = (j_q == LAW'(C - 1)) ? '0 : j_q + 1'b1;
        it_d      = it_q + 1'b1;
        state_d   = (it_q == ITW'(NIT - 1)) ? DONE : MIX_RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write data holds its last written value between writes
  always_comb begin
    l_wd_d = l_wd_q;
    s_wd_d = s_wd_q;
    if (l_we_c) l_wd_d = l_wdata_c;
    if (s_we_c) s_wd_d = s_wdata_c;
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign key_address   = key_addr_c;
  assign L_address     = l_addr_c;
  assign L_we          = l_we_c & ~rst;
  assign L_sub_i_prima = l_wdata_c;
  assign S_address     = s_addr_c;
  assign S_we          = s_we_c & ~rst;
  assign S_sub_i_prima = s_wdata_c;

endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

Parametrised RC5 key-expansion engine: the successor to the key-to-L converter. It handles any word width, round count and key length, and runs the complete schedule: key-to-L load, S-table initialisation and the 3·max(T,C) mixing pass. It drives three external single-port synchronous RAMs (key bytes, L words, S words) and is launched by a start/done handshake from the RC5 datapath controller.

## Interface
- W, 32, word width in bits; power of two, 16/32/64
- R, 12, number of rounds
- B, 16, key length in bytes, 1..255
- P, 32'hB7E15163, magic constant Pw (W bits)
- Q, 32'h9E3779B9, magic constant Qw (W bits)
- Derived: U=W/8, C=max(1,ceil(B/U)), T=2(R+1), M=max(T,C); address widths $clog2 of B, C, T (min 1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request, sampled in IDLE only
- busy  out  1  high from the first LOAD cycle through DONE
- done  out  1  one-cycle pulse, schedule complete
- key_address  out  $clog2(B)  key RAM read address
- key_sub_i  in  8  key RAM read data, valid 1 cycle after address
- L_address  out  $clog2(C)  L RAM address
- L_sub_i  in  W  L RAM read data, 1-cycle latency
- L_sub_i_prima  out  W  L RAM write data
- L_we  out  1  L RAM write enable
- S_address  out  $clog2(T)  S RAM address
- S_sub_i  in  W  S RAM read data, 1-cycle latency
- S_sub_i_prima  out  W  S RAM write data
- S_we  out  1  S RAM write enable

## Operation
- FSM: IDLE → LOAD → LDRAIN → SINIT → MIX_RD ⇄ MIX_WR → DONE → IDLE.
- IDLE: start=1 → LOAD; clear A, B, acc, i, j.
- LOAD: byte index k counts B-1 down to 0, one per cycle; key_address=k.
- Accumulator: byte k's data arrives the following cycle; acc_n = (acc<<8)|key_sub_i.
- When k%U==0, in that data cycle: L_we=1, L_address=k/U, L_sub_i_prima=acc_n; acc cleared afterwards.
- A partial top word (B%U≠0) is zero-padded in its high bytes by construction. L is never pre-cleared.
- LDRAIN: consumes the data of k=0, then → SINIT.
- SINIT: T cycles writing S[n]=P+n·Q mod 2^W, n=0..T-1, with S_we=1. Running sum is held in a register (no multiplier).
- MIX_RD: S_address=i, L_address=j; no write.
- MIX_WR: A'=rotl(S_sub_i+A+B, 3); B'=rotl(L_sub_i+A'+B, (A'+B)[log2W-1:0]).
  - Write S[i]=A' and L[j]=B' in the same cycle.
  - Update A, B; i=(i+1) mod T, j=(j+1) mod C.
  - Iteration counter increments; after 3M iterations → DONE, else → MIX_RD.
- All additions are mod 2^W; rotate amount uses only the low log2(W) bits.
- DONE: done=1 for one cycle, busy=1, → IDLE.
- start while busy is ignored; start in the DONE cycle is ignored; a restart requires start in IDLE.

## Timing
- Reset: busy=0, done=0, all addresses 0, both write enables 0, both write data 0, state IDLE, A=B=0.
- Reset in any state returns to IDLE next cycle with no further writes. RAM contents are left partial and undefined.
- Cycle 1 is the first cycle after start is sampled. Cycles 1..B: LOAD; B+1: LDRAIN; next T: SINIT; next 6M: MIX; then DONE.
- done is high in cycle B+T+6M+2.
- Each write enable is high only in its write cycle, with address and data valid the same cycle. No read and write to the same RAM occur in one cycle.
- C=1 case: L[0] written in MIX_WR is read back in the next MIX_RD, so the RAM must return the new value (write-then-read in separate cycles).
- When no write is in progress, write data holds the last value; verification ignores it.

## Test plan
- W=32, R=12, B=16, key[n]=5+n, write monitor on L → L writes in order L[3]=0x14131211, L[2]=0x100F0E0D, L[1]=0x0C0B0A09, L[0]=0x08070605. Then S[0]=0xB7E15163, S[1]=0x5618CB1C, S[25]=P+25Q. done in cycle 16+26+156+2=200; final S[0..25] and L[0..3] match the golden model.
- W=32, B=5, key[n]=5+n → L[1]=0x00000009, L[0]=0x08070605 (C=2); total latency 5+26+156+2=189; final tables match the golden model.
- W=16, R=4, B=2, P=16'hB7E1, Q=16'h9E37 (C=1, T=10) → L[0]=key[1]·256+key[0]; 30 mix iterations; done at cycle 2+10+60+2=74; final tables match the golden model.
- start pulsed again at cycles 10 and 100 of a run → ignored; exactly one done; busy high continuously through DONE.
- rst asserted in cycle 50 of a run → next cycle busy=0, done=0, L_we=S_we=0, no write thereafter. A new start then completes with results identical to a clean run.
- All-zero key, W=32, R=12, B=16 → final S matches the golden model; every done pulse is exactly 1 cycle wide.
